// File: rtl/lsnn_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsnn_dec_pkg
// Purpose  : Shared types and constants for the LSNN spike decoder.
// Revision : 1.0 - initial release
// ============================================================================
package lsnn_dec_pkg;

    // Default build-time sizes of the decoder.
    localparam int DEF_WIN_LEN = 64;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_ISI_W   = 8;
    localparam int DEF_THR_W   = 8;

    // All-ones minimum-ISI sentinel meaning no interval was measured.
    localparam logic [DEF_ISI_W-1:0] MIN_ISI_NONE = '1;

    // Decoder control state.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // One window result at the default widths, packed in slot order.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_ISI_W-1:0] min_isi;
        logic [DEF_THR_W-1:0] thr_max;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/lsnn_result_slot.sv
`default_nettype none
// ============================================================================
// Module   : lsnn_result_slot
// Purpose  : Single-entry valid/ready holding register. A load into a full,
//            unaccepted slot is discarded and flagged by a sticky drop bit.
// Revision : 1.0 - initial release
// ============================================================================
module lsnn_result_slot
    import lsnn_dec_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_drop
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_drop;

    // Load, accept and overflow tracking; a handshake in the load cycle frees the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_drop  <= 1'b0;
        end else if (i_load) begin
            if (!r_valid || i_ready) begin
                r_data  <= i_load_data;
                r_valid <= 1'b1;
            end else begin
                r_drop  <= 1'b1;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_drop  = r_drop;

endmodule
`default_nettype wire

// File: rtl/lsnn_spike_decoder.sv
`default_nettype none
// ============================================================================
// Module   : lsnn_spike_decoder
// Purpose  : Reduces the neuron spike/threshold stream over fixed windows to
//            spike count, minimum inter-spike interval and peak threshold.
// Revision : 1.0 - initial release
// ============================================================================
module lsnn_spike_decoder
    import lsnn_dec_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int ISI_W   = DEF_ISI_W,
    parameter int THR_W   = DEF_THR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike_in,
    input  logic [THR_W-1:0] thr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ISI_W-1:0] out_min_isi,
    output logic [THR_W-1:0] out_thr_max,
    output logic             out_drop,
    output logic             busy
);

    localparam int                 c_WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;
    localparam logic [ISI_W-1:0]   c_ISI_MAX  = '1;
    localparam int                 c_DATA_W   = CNT_W + ISI_W + THR_W;

    state_t             r_state;
    logic [c_WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0]   r_spike_cnt;
    logic [THR_W-1:0]   r_thr_max;
    logic [ISI_W-1:0]   r_min_isi;
    logic [ISI_W-1:0]   r_isi_cnt;
    logic               r_seen_first;

    logic               w_sample;
    logic               w_last;
    logic [CNT_W-1:0]   w_cnt_acc;
    logic [THR_W-1:0]   w_thr_acc;
    logic [ISI_W-1:0]   w_min_acc;
    logic [ISI_W-1:0]   w_isi_nxt;
    logic [c_DATA_W-1:0] w_slot_data;

    // Window statistics with this cycle's sample folded in.
    always_comb begin
        w_sample  = (r_state == ACCUM) && en;
        w_last    = w_sample && (r_win_cnt == c_WIN_LAST);
        w_cnt_acc = (spike_in && (r_spike_cnt != c_CNT_MAX)) ? r_spike_cnt + CNT_W'(1) : r_spike_cnt;
        w_thr_acc = (thr_in > r_thr_max) ? thr_in : r_thr_max;
        w_min_acc = (spike_in && r_seen_first && (r_isi_cnt < r_min_isi)) ? r_isi_cnt : r_min_isi;
        // Distance to the next sample: 1 just after a spike, otherwise one more, saturating.
        if (spike_in) begin
            w_isi_nxt = ISI_W'(1);
        end else if (r_isi_cnt != c_ISI_MAX) begin
            w_isi_nxt = r_isi_cnt + ISI_W'(1);
        end else begin
            w_isi_nxt = r_isi_cnt;
        end
    end

    // Control FSM, window counter, accumulators and ISI tracker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_win_cnt    <= '0;
            r_spike_cnt  <= '0;
            r_thr_max    <= '0;
            r_min_isi    <= c_ISI_MAX;
            r_isi_cnt    <= '0;
            r_seen_first <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!en) begin
                        // Abandon the partial window and forget spike history.
                        r_state      <= IDLE;
                        r_win_cnt    <= '0;
                        r_spike_cnt  <= '0;
                        r_thr_max    <= '0;
                        r_min_isi    <= c_ISI_MAX;
                        r_isi_cnt    <= '0;
                        r_seen_first <= 1'b0;
                    end else begin
                        // ISI history carries across window boundaries.
                        r_isi_cnt <= w_isi_nxt;
                        if (spike_in) begin
                            r_seen_first <= 1'b1;
                        end
                        if (w_last) begin
                            r_win_cnt   <= '0;
                            r_spike_cnt <= '0;
                            r_thr_max   <= '0;
                            r_min_isi   <= c_ISI_MAX;
                        end else begin
                            r_win_cnt   <= r_win_cnt + c_WIN_W'(1);
                            r_spike_cnt <= w_cnt_acc;
                            r_thr_max   <= w_thr_acc;
                            r_min_isi   <= w_min_acc;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_slot_data = {w_cnt_acc, w_min_acc, w_thr_acc};

    lsnn_result_slot #(
        .DATA_W (c_DATA_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_last),
        .i_load_data (w_slot_data),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      ({out_count, out_min_isi, out_thr_max}),
        .o_drop      (out_drop)
    );

    assign busy = (r_state == ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_lsnn_spike_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsnn_spike_decoder
// Purpose  : Directed self-checking bench for lsnn_spike_decoder, using a
//            short-window instance and a long-window saturation instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsnn_spike_decoder;
    import lsnn_dec_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Short-window instance (WIN_LEN = 8).
    logic       en_a = 1'b0, spike_a = 1'b0, ready_a = 1'b1;
    logic [7:0] thr_a = 8'h00;
    logic       valid_a, drop_a, busy_a;
    logic [7:0] count_a, isi_a, tmax_a;

    // Long-window instance (WIN_LEN = 300).
    logic       en_b = 1'b0, spike_b = 1'b0, ready_b = 1'b1;
    logic [7:0] thr_b = 8'h00;
    logic       valid_b, drop_b, busy_b;
    logic [7:0] count_b, isi_b, tmax_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsnn_spike_decoder #(.WIN_LEN(8), .CNT_W(8), .ISI_W(8), .THR_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .spike_in(spike_a), .thr_in(thr_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_count(count_a),
        .out_min_isi(isi_a), .out_thr_max(tmax_a), .out_drop(drop_a), .busy(busy_a)
    );

    lsnn_spike_decoder #(.WIN_LEN(300), .CNT_W(8), .ISI_W(8), .THR_W(8)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .spike_in(spike_b), .thr_in(thr_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_count(count_b),
        .out_min_isi(isi_b), .out_thr_max(tmax_b), .out_drop(drop_b), .busy(busy_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive samples first..last of a window on instance A, one per clock.
    task automatic run_a(input logic [7:0] spk, input logic [63:0] thr,
                         input logic [7:0] rdy, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            spike_a = spk[i];
            thr_a   = thr[i*8 +: 8];
            ready_a = rdy[i];
            step();
        end
    endtask

    task automatic check_a(input string tag, input logic v, input result_t r, input logic d);
        check_val({tag, "_valid"}, 32'(valid_a), 32'(v));
        check_val({tag, "_count"}, 32'(count_a), 32'(r.count));
        check_val({tag, "_isi"},   32'(isi_a),   32'(r.min_isi));
        check_val({tag, "_thr"},   32'(tmax_a),  32'(r.thr_max));
        check_val({tag, "_drop"},  32'(drop_a),  32'(d));
    endtask

    initial begin
        step();
        step();
        // Reset state.
        check_a("rst", 1'b0, '{8'd0, 8'd0, 8'd0}, 1'b0);
        check_val("rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;

        // One IDLE cycle whose inputs must be ignored.
        en_a = 1'b1; spike_a = 1'b1; thr_a = 8'hEE;
        step();
        check_val("w1_busy", 32'(busy_a), 32'd1);

        // W1: spikes at 1,4,5; threshold pattern 10,20,99,00.
        run_a(8'b0011_0010, 64'h00992010_00992010, 8'hFF, 0, 7);
        check_a("w1", 1'b1, '{8'd3, 8'd1, 8'h99}, 1'b0);

        // W2: no spikes, constant 0x10; W1 result taken on first cycle.
        run_a(8'h00, 64'h10101010_10101010, 8'hFF, 0, 0);
        check_val("w2_accept", 32'(valid_a), 32'd0);
        run_a(8'h00, 64'h10101010_10101010, 8'hFF, 1, 7);
        check_a("w2", 1'b1, '{8'd0, MIN_ISI_NONE, 8'h10}, 1'b0);

        // W3: back-to-back, identical result.
        run_a(8'h00, 64'h10101010_10101010, 8'hFF, 0, 7);
        check_a("w3", 1'b1, '{8'd0, MIN_ISI_NONE, 8'h10}, 1'b0);

        // W4: spikes at 0 and 7; first ISI spans windows (19), second is 7.
        run_a(8'b1000_0001, 64'h47464544_43424140, 8'b0000_0001, 0, 7);
        check_a("w4", 1'b1, '{8'd2, 8'd7, 8'h47}, 1'b0);

        // W5: ready only on the completion edge -> swap, no drop.
        run_a(8'b0010_0100, 64'h30313030_30303030, 8'b1000_0000, 0, 6);
        check_a("w5_hold", 1'b1, '{8'd2, 8'd7, 8'h47}, 1'b0);
        run_a(8'b0010_0100, 64'h30313030_30303030, 8'b1000_0000, 7, 7);
        check_a("w5", 1'b1, '{8'd2, 8'd3, 8'h31}, 1'b0);

        // W6: completes into a full slot with ready low -> discarded, drop set.
        run_a(8'h00, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 0, 7);
        check_a("w6_drop", 1'b1, '{8'd2, 8'd3, 8'h31}, 1'b1);

        // W7: ready on first cycle empties the slot; drop stays.
        run_a(8'h00, 64'h05050505_05050505, 8'b0000_0001, 0, 0);
        check_val("w7_accept", 32'(valid_a), 32'd0);
        check_val("w7_drop", 32'(drop_a), 32'd1);
        run_a(8'h00, 64'h05050505_05050505, 8'b0000_0001, 1, 7);
        check_a("w7", 1'b1, '{8'd0, MIN_ISI_NONE, 8'h05}, 1'b1);

        // W8: asynchronous reset mid-window with a result pending.
        run_a(8'h00, 64'h06060606_06060606, 8'h00, 0, 2);
        #2 rst = 1'b1;
        #1;
        check_a("arst", 1'b0, '{8'd0, 8'd0, 8'd0}, 1'b0);
        check_val("arst_busy", 32'(busy_a), 32'd0);
        #1 rst = 1'b0;
        spike_a = 1'b1; thr_a = 8'hEE; ready_a = 1'b1;
        step();
        run_a(8'h00, 64'h22222222_22222222, 8'hFF, 0, 6);
        check_val("post_rst_early", 32'(valid_a), 32'd0);
        run_a(8'h00, 64'h22222222_22222222, 8'hFF, 7, 7);
        check_a("post_rst", 1'b1, '{8'd0, MIN_ISI_NONE, 8'h22}, 1'b0);
        en_a = 1'b0;

        // Instance B: spike every cycle over 300 samples saturates the count.
        en_b = 1'b1; spike_b = 1'b1; thr_b = 8'h07;
        step();
        check_val("b_busy", 32'(busy_b), 32'd1);
        for (int i = 0; i < 299; i++) step();
        check_val("b_early", 32'(valid_b), 32'd0);
        step();
        check_val("b_valid", 32'(valid_b), 32'd1);
        check_val("b_count", 32'(count_b), 32'd255);
        check_val("b_isi",   32'(isi_b),   32'd1);
        check_val("b_thr",   32'(tmax_b),  32'h07);

        // Abort at win_cnt = 100.
        for (int i = 0; i < 100; i++) step();
        en_b = 1'b0;
        step();
        check_val("b_abort_busy", 32'(busy_b), 32'd0);
        check_val("b_abort_valid", 32'(valid_b), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check_val("b_idle_valid", 32'(valid_b), 32'd0);

        // Fresh window after re-enable: spikes at 10 and 13, peak 0x80 at 200.
        en_b = 1'b1; spike_b = 1'b1; thr_b = 8'hF0;
        step();
        for (int i = 0; i < 299; i++) begin
            spike_b = (i == 10) || (i == 13);
            thr_b   = (i == 200) ? 8'h80 : 8'h03;
            step();
        end
        check_val("b2_early", 32'(valid_b), 32'd0);
        spike_b = 1'b0; thr_b = 8'h03;
        step();
        check_val("b2_valid", 32'(valid_b), 32'd1);
        check_val("b2_count", 32'(count_b), 32'd2);
        check_val("b2_isi",   32'(isi_b),   32'd3);
        check_val("b2_thr",   32'(tmax_b),  32'h80);
        check_val("b2_drop",  32'(drop_b),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsnn_spike_decoder.md
Name: lsnn_spike_decoder

Overview:
Downstream stage of the LSNN adaptive-threshold neuron. It consumes the neuron's per-cycle spike bit and current threshold value. Over fixed windows of WIN_LEN cycles it reduces them to three statistics: spike rate, minimum inter-spike interval and peak threshold. Each window result is handed to the consumer (readout/host interface) through a single-entry valid/ready output slot.

Parameters:
WIN_LEN, 64, cycles per accumulation window (2..65535)
CNT_W, 8, width of spike-count result (saturating)
ISI_W, 8, width of inter-spike-interval result (saturating)
THR_W, 8, width of threshold input/peak result

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  accumulate enable; low = idle, partial window discarded
spike_in  input  1  neuron spike for this cycle
thr_in  input  THR_W  neuron adaptive threshold for this cycle
out_valid  output  1  window result available
out_ready  input  1  consumer accepts result when out_valid & out_ready
out_count  output  CNT_W  spikes in window
out_min_isi  output  ISI_W  smallest spike-to-spike distance in window; all-ones = none measured
out_thr_max  output  THR_W  max thr_in sampled in window
out_drop  output  1  sticky: a completed window was discarded
busy  output  1  high while in ACCUM

Behaviour:
- Reset (async, any time, incl. mid-window): FSM=IDLE. Window counter, accumulators, ISI tracker cleared. out_valid, out_count, out_min_isi, out_thr_max, out_drop, busy all 0.
- FSM states:
  - IDLE: busy=0. On en=1 go to ACCUM next edge. The first sample is taken in the first ACCUM cycle.
  - ACCUM: busy=1. Samples spike_in/thr_in every cycle. en=0 -> IDLE next edge. That cycle's sample is not taken. win_cnt, accumulators, ISI tracker and seen_first are cleared. The output slot is untouched.
- Accumulation (ACCUM), one sample per cycle:
  - win_cnt 0..WIN_LEN-1.
  - spike_cnt += spike_in, saturating at 2^CNT_W-1.
  - thr_max = max(thr_max, thr_in), unsigned.
- ISI:
  - isi_cnt counts cycles since the last spike, saturating at 2^ISI_W-1.
  - On a spike with seen_first=1, candidate = t - t_prev (saturated), and min_isi = min(min_isi, candidate).
  - Each spike restarts isi_cnt and sets seen_first.
  - The ISI tracker and seen_first persist across window boundaries. min_isi restarts at all-ones each window.
- Window completion:
  - At the edge ending the cycle with win_cnt==WIN_LEN-1, that cycle's sample is folded in. The final values go to the slot, so out_valid rises 1 cycle after the last sample.
  - Accumulators reset to initial values (count 0, thr_max 0, min_isi all-ones) and win_cnt=0.
  - Windows run back-to-back with no gap cycle.
- Output slot:
  - The result holds stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready with no completion -> out_valid=0 next edge.
  - Completion with slot empty, or with a handshake in the same cycle -> new result loaded, out_valid=1, no drop.
  - Completion with out_valid=1 & out_ready=0 -> new result discarded, old result kept, out_drop=1 until rst.
  - out_ready is ignored when out_valid=0.
- No combinational path from any input to any output.

Decomposition:
- Package lsnn_dec_pkg:
  - FSM state enum {IDLE, ACCUM}
  - MIN_ISI_NONE (all-ones of ISI_W)
  - default parameter constants
  - result struct {count, min_isi, thr_max}
- Sub-module lsnn_result_slot: single-entry valid/ready holding register with load, accept and sticky drop logic.
- Accumulators and FSM live in lsnn_spike_decoder.

Test Plan:
1. WIN_LEN=8, en=1, out_ready=1; spikes at window cycles 1,4,5; thr_in 0x10,0x20,0x99,0x00 pattern -> one cycle after the last sample: out_valid=1, out_count=3, out_min_isi=1, out_thr_max=0x99.
2. WIN_LEN=8, no spikes, thr_in constant 0x10 -> out_count=0, out_min_isi=0xFF, out_thr_max=0x10. Next window starts with no gap and gives the same result.
3. out_ready=0 across two completions -> first result held unchanged, out_drop=1 after the second completion. Raising out_ready -> out_valid=0 next edge, out_drop stays 1.
4. out_ready=1 exactly on the completion edge of the next window -> old result accepted, new result loaded, out_valid stays 1, out_drop=0.
5. WIN_LEN=300, CNT_W=8, spike every cycle -> out_count=255 (saturated), out_min_isi=1. Then en=0 at win_cnt=100 -> busy=0 next edge, no result produced. en=1 again -> next result covers a full fresh window.
6. Assert rst mid-window with out_valid=1 -> all outputs 0 immediately (async). After release with en=1, the first result appears WIN_LEN+1 cycles later.
